// File: rtl/rv_decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU operations and mux selects.
// Also holds the bundle of registered controls and the funct3-to-ALU mapping.
package rv_decode_pkg;

    localparam int XLEN            = 32;
    localparam int ALU_OP_WIDTH    = 4;
    localparam int SEL_SRC_A_WIDTH = 2;
    localparam int SEL_SRC_B_WIDTH = 2;
    localparam int SEL_PC_WIDTH    = 2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_SEQ  = 4'd10, ALU_SNE  = 4'd11,
        ALU_SGE  = 4'd12, ALU_SGEU = 4'd13
    } alu_op_e;

    typedef enum logic [SEL_SRC_A_WIDTH-1:0] {
        SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2
    } src_a_e;

    typedef enum logic [SEL_SRC_B_WIDTH-1:0] {
        SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2
    } src_b_e;

    typedef enum logic [SEL_PC_WIDTH-1:0] {
        PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3
    } pc_e;

    typedef struct packed {
        alu_op_e alu_op;
        src_a_e  src_a;
        src_b_e  src_b;
        pc_e     pc;
        logic    wb;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op: ALU_ADD, src_a: SRC_A_RS1, src_b: SRC_B_RS2, pc: PC_PLUS4, wb: 1'b0
    };

    // alt comes from funct7[5]; it only matters for the ADD/SUB and SRL/SRA slots.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J layout from the opcode.
// R-type and unrecognised opcodes produce zero.
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [XLEN-1:0] code,
    output logic [XLEN-1:0] imm
);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        imm = '0;
        case (code[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{code[31]}}, code[31:20]};
            OPC_STORE:
                imm = {{20{code[31]}}, code[31:25], code[11:7]};
            OPC_BRANCH:
                imm = {{19{code[31]}}, code[31], code[7], code[30:25], code[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {code[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{code[31]}}, code[31], code[19:12], code[20], code[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode.sv
// RV32I decode stage: register numbers, immediate and execute controls, all registered.
// Optional `ILLEGAL_INSN_EN adds a registered `illegal` flag; controls are unaffected by it.
module rv32i_decode
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [XLEN-1:0]            code,
    output logic [4:0]                 rs1_num,
    output logic [4:0]                 rs2_num,
    output logic [4:0]                 rd_num,
    output logic [XLEN-1:0]            imm,
    output logic [ALU_OP_WIDTH-1:0]    alu_op_sel,
    output logic [SEL_SRC_A_WIDTH-1:0] src_a_sel,
    output logic [SEL_SRC_B_WIDTH-1:0] src_b_sel,
    output logic [SEL_PC_WIDTH-1:0]    pc_sel,
    output logic                       wb_reg
`ifdef ILLEGAL_INSN_EN
    ,
    output logic                       illegal
`endif
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = code[6:0];
    assign funct3 = code[14:12];
    assign funct7 = code[31:25];

    logic [XLEN-1:0] imm_d, imm_q;
    ctrl_t           ctrl_d, ctrl_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;

    imm_gen u_imm_gen (
        .code (code),
        .imm  (imm_d)
    );

    always_comb begin
        ctrl_d = CTRL_NOP;
        case (opcode)
            OPC_OP: begin
                ctrl_d.alu_op = alu_from_funct3(funct3, funct7[5]);
                ctrl_d.wb     = 1'b1;
            end
            OPC_OP_IMM: begin
                // No SUBI exists, so funct7[5] only counts in the shift-right slot.
                ctrl_d.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                ctrl_d.src_b  = SRC_B_IMM;
                ctrl_d.wb     = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.src_b = SRC_B_IMM;
                ctrl_d.wb    = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.src_b = SRC_B_IMM;
            end
            OPC_BRANCH: begin
                ctrl_d.pc = PC_BRANCH;
                case (funct3)
                    3'b001:  ctrl_d.alu_op = ALU_SNE;
                    3'b100:  ctrl_d.alu_op = ALU_SLT;
                    3'b101:  ctrl_d.alu_op = ALU_SGE;
                    3'b110:  ctrl_d.alu_op = ALU_SLTU;
                    3'b111:  ctrl_d.alu_op = ALU_SGEU;
                    default: ctrl_d.alu_op = ALU_SEQ;
                endcase
            end
            OPC_LUI: begin
                ctrl_d.src_a = SRC_A_ZERO;
                ctrl_d.src_b = SRC_B_IMM;
                ctrl_d.wb    = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_d.src_a = SRC_A_PC;
                ctrl_d.src_b = SRC_B_IMM;
                ctrl_d.wb    = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // The link value pc+4 goes through the ALU; the jump target is formed outside.
                ctrl_d.src_a = SRC_A_PC;
                ctrl_d.src_b = SRC_B_FOUR;
                ctrl_d.pc    = (opcode == OPC_JAL) ? PC_JAL : PC_JALR;
                ctrl_d.wb    = 1'b1;
            end
            default: ctrl_d = CTRL_NOP;
        endcase
        if (code[11:7] == 5'd0) begin
            ctrl_d.wb = 1'b0;
        end
    end

`ifdef ILLEGAL_INSN_EN
    logic illegal_d, illegal_q;

    always_comb begin
        illegal_d = 1'b0;
        case (opcode)
            OPC_OP:
                illegal_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            OPC_OP_IMM: begin
                if (funct3 == 3'b001) begin
                    illegal_d = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal_d = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OPC_BRANCH:
                illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                illegal_d = 1'b0;
            default:
                illegal_d = 1'b1;
        endcase
        if (code[1:0] != 2'b11) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

    // NOTE: state flops use non-blocking assignments and clear on the async reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
            imm_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            imm_q  <= imm_d;
            rs1_q  <= code[19:15];
            rs2_q  <= code[24:20];
            rd_q   <= code[11:7];
        end
    end

    assign rs1_num    = rs1_q;
    assign rs2_num    = rs2_q;
    assign rd_num     = rd_q;
    assign imm        = imm_q;
    assign alu_op_sel = ctrl_q.alu_op;
    assign src_a_sel  = ctrl_q.src_a;
    assign src_b_sel  = ctrl_q.src_b;
    assign pc_sel     = ctrl_q.pc;
    assign wb_reg     = ctrl_q.wb;

endmodule

// File: tb/tb_rv32i_decode.sv
// Self-checking bench for rv32i_decode: expected outputs are queued as each instruction
// is driven and compared once the registered outputs appear.
module tb_rv32i_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] code = '0;
    logic [4:0]  rs1_num, rs2_num, rd_num;
    logic [31:0] imm;
    logic [3:0]  alu_op_sel;
    logic [1:0]  src_a_sel, src_b_sel, pc_sel;
    logic        wb_reg;
`ifdef ILLEGAL_INSN_EN
    logic        illegal;
`endif

    rv32i_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .rs1_num    (rs1_num),
        .rs2_num    (rs2_num),
        .rd_num     (rd_num),
        .imm        (imm),
        .alu_op_sel (alu_op_sel),
        .src_a_sel  (src_a_sel),
        .src_b_sel  (src_b_sel),
        .pc_sel     (pc_sel),
        .wb_reg     (wb_reg)
`ifdef ILLEGAL_INSN_EN
        ,
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] code;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  pc;
        logic        wb;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] c);
        exp_t       e;
        logic [6:0] f7;
        logic [2:0] f3;
        e      = '0;
        f7     = c[31:25];
        f3     = c[14:12];
        e.code = c;
        e.rs1  = c[19:15];
        e.rs2  = c[24:20];
        e.rd   = c[11:7];
        case (c[6:0])
            7'h33: begin
                e.wb  = 1'b1;
                e.ill = !(f7 == 7'h00 || f7 == 7'h20);
                case (f3)
                    3'd0: e.alu = f7[5] ? 4'd1 : 4'd0;
                    3'd1: e.alu = 4'd2;
                    3'd2: e.alu = 4'd3;
                    3'd3: e.alu = 4'd4;
                    3'd4: e.alu = 4'd5;
                    3'd5: e.alu = f7[5] ? 4'd7 : 4'd6;
                    3'd6: e.alu = 4'd8;
                    default: e.alu = 4'd9;
                endcase
            end
            7'h13: begin
                e.imm = {{20{c[31]}}, c[31:20]};
                e.b   = 2'd1;
                e.wb  = 1'b1;
                case (f3)
                    3'd0: e.alu = 4'd0;
                    3'd1: begin e.alu = 4'd2; e.ill = (f7 != 7'h00); end
                    3'd2: e.alu = 4'd3;
                    3'd3: e.alu = 4'd4;
                    3'd4: e.alu = 4'd5;
                    3'd5: begin
                        e.alu = f7[5] ? 4'd7 : 4'd6;
                        e.ill = !(f7 == 7'h00 || f7 == 7'h20);
                    end
                    3'd6: e.alu = 4'd8;
                    default: e.alu = 4'd9;
                endcase
            end
            7'h03: begin e.imm = {{20{c[31]}}, c[31:20]}; e.b = 2'd1; e.wb = 1'b1; end
            7'h23: begin e.imm = {{20{c[31]}}, c[31:25], c[11:7]}; e.b = 2'd1; end
            7'h63: begin
                e.imm = {{20{c[31]}}, c[7], c[30:25], c[11:8], 1'b0};
                e.pc  = 2'd1;
                case (f3)
                    3'd0: e.alu = 4'd10;
                    3'd1: e.alu = 4'd11;
                    3'd4: e.alu = 4'd3;
                    3'd5: e.alu = 4'd12;
                    3'd6: e.alu = 4'd4;
                    3'd7: e.alu = 4'd13;
                    default: begin e.alu = 4'd10; e.ill = 1'b1; end
                endcase
            end
            7'h37: begin e.imm = {c[31:12], 12'h000}; e.a = 2'd2; e.b = 2'd1; e.wb = 1'b1; end
            7'h17: begin e.imm = {c[31:12], 12'h000}; e.a = 2'd1; e.b = 2'd1; e.wb = 1'b1; end
            7'h6F: begin
                e.imm = {{12{c[31]}}, c[19:12], c[20], c[30:21], 1'b0};
                e.a = 2'd1; e.b = 2'd2; e.pc = 2'd2; e.wb = 1'b1;
            end
            7'h67: begin
                e.imm = {{20{c[31]}}, c[31:20]};
                e.a = 2'd1; e.b = 2'd2; e.pc = 2'd3; e.wb = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (c[11:7] == 5'd0) e.wb = 1'b0;
        if (c[1:0] != 2'b11) e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] im, input logic [3:0] alu,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] pc,
                                input logic wb, input logic ill);
        exp_t e;
        e = '{code: c, rs1: rs1, rs2: rs2, rd: rd, imm: im, alu: alu,
              a: a, b: b, pc: pc, wb: wb, ill: ill};
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("rs1[%h]", e.code), 32'(rs1_num), 32'(e.rs1));
            check($sformatf("rs2[%h]", e.code), 32'(rs2_num), 32'(e.rs2));
            check($sformatf("rd[%h]", e.code), 32'(rd_num), 32'(e.rd));
            check($sformatf("imm[%h]", e.code), imm, e.imm);
            check($sformatf("alu[%h]", e.code), 32'(alu_op_sel), 32'(e.alu));
            check($sformatf("src_a[%h]", e.code), 32'(src_a_sel), 32'(e.a));
            check($sformatf("src_b[%h]", e.code), 32'(src_b_sel), 32'(e.b));
            check($sformatf("pc[%h]", e.code), 32'(pc_sel), 32'(e.pc));
            check($sformatf("wb[%h]", e.code), 32'(wb_reg), 32'(e.wb));
`ifdef ILLEGAL_INSN_EN
            check($sformatf("illegal[%h]", e.code), 32'(illegal), 32'(e.ill));
`endif
        end
    endtask

    task automatic apply(input exp_t e);
        @(negedge clk);
        code = e.code;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rs1"}, 32'(rs1_num), 32'd0);
        check({tag, "_rs2"}, 32'(rs2_num), 32'd0);
        check({tag, "_rd"}, 32'(rd_num), 32'd0);
        check({tag, "_imm"}, imm, 32'd0);
        check({tag, "_alu"}, 32'(alu_op_sel), 32'd0);
        check({tag, "_src_a"}, 32'(src_a_sel), 32'd0);
        check({tag, "_src_b"}, 32'(src_b_sel), 32'd0);
        check({tag, "_pc"}, 32'(pc_sel), 32'd0);
        check({tag, "_wb"}, 32'(wb_reg), 32'd0);
`ifdef ILLEGAL_INSN_EN
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] opc_tab [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};
    logic [31:0] dir_tab [14] = '{
        32'h40208033,  // sub  x0-rd ... rd=0 forces wb=0
        32'h402081B3,  // sub  x3,x1,x2
        32'h4020D1B3,  // sra  x3,x1,x2
        32'h0020F1B3,  // and  x3,x1,x2
        32'h0220C1B3,  // OP with funct7=0x01
        32'h4030D193,  // srai x3,x1,3
        32'h02309193,  // slli with bad funct7
        32'hFFF0C193,  // xori x3,x1,-1
        32'h00209463,  // bne
        32'h0020A463,  // branch funct3=010
        32'h0020F463,  // bgeu
        32'h123450E7,  // jalr-encoded as 0x67 opcode? (0xE7 -> 1100111)
        32'h12345097,  // auipc x1
        32'h00000010   // low bits 00
    };

    initial begin
        code = 32'hDEADBEEF;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        apply(mk(32'hF0F08113, 5'd1, 5'd15, 5'd2,  32'hFFFFFF0F, 4'd0,  2'd0, 2'd1, 2'd0, 1'b1, 1'b0));
        apply(mk(32'hFE110023, 5'd2, 5'd1,  5'd0,  32'hFFFFFFE0, 4'd0,  2'd0, 2'd1, 2'd0, 1'b0, 1'b0));
        apply(mk(32'h222085E3, 5'd1, 5'd2,  5'd11, 32'h00000A2A, 4'd10, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0));
        apply(mk(32'hF0F0F0B7, 5'd1, 5'd15, 5'd1,  32'hF0F0F000, 4'd0,  2'd2, 2'd1, 2'd0, 1'b1, 1'b0));
        apply(mk(32'h801000EF, 5'd0, 5'd1,  5'd1,  32'hFFF00800, 4'd0,  2'd1, 2'd2, 2'd2, 1'b1, 1'b0));

        foreach (dir_tab[i]) apply(model(dir_tab[i]));

        for (int i = 0; i < 60; i++) begin
            logic [31:0] r;
            logic [6:0]  op;
            r  = $urandom();
            op = opc_tab[$urandom_range(0, 9)];
            r[6:0] = op;
            if ((op == 7'h33 || op == 7'h13) && r[0]) r[31:25] = r[1] ? 7'h20 : 7'h00;
            apply(model(r));
        end

        // Asynchronous reset in the middle of the stream, between clock edges.
        @(negedge clk);
        code = 32'hF0F0F0B7;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(32'h00000000, 5'd0, 5'd0, 5'd0, 32'h0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1));
        apply(model(32'hF0F08113));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_decode.md
Name: rv32i_decode

Overview:
- RV32I instruction decoder stage: splits a 32-bit instruction word into register numbers and a sign-extended immediate.
- Generates ALU-op, operand-mux, PC-mux and write-back controls.
- Sits between fetch and the register-file/ALU execute stage.
- All outputs are registered: one clock of latency.

Parameters:
- XLEN, 32, instruction and immediate width (only 32 supported).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- code  in  32  instruction word, sampled every rising edge
- rs1_num  out  5  code[19:15]
- rs2_num  out  5  code[24:20]
- rd_num  out  5  code[11:7]
- imm  out  32  decoded sign-extended immediate
- alu_op_sel  out  4  ALU operation (ALU_OP_WIDTH=4)
- src_a_sel  out  2  ALU A mux (SEL_SRC_A_WIDTH=2)
- src_b_sel  out  2  ALU B mux (SEL_SRC_B_WIDTH=2)
- pc_sel  out  2  next-PC mux (SEL_PC_WIDTH=2)
- wb_reg  out  1  write ALU/load result to rd

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: every output is 0 (ALU_ADD, SRC_A_RS1, SRC_B_RS2, PC_PLUS4, wb_reg=0).
- Latency: outputs reflect `code` captured at the previous rising edge. No handshake; a new instruction is accepted every cycle.
- Register fields: rs1_num, rs2_num and rd_num are always the raw fields, whatever the format.
- Encodings:
  - ALU: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, SEQ=10, SNE=11, SGE=12, SGEU=13.
  - SRC_A: RS1=0, PC=1, ZERO=2.
  - SRC_B: RS2=0, IMM=1, FOUR=2.
  - PC: PLUS4=0, BRANCH=1, JAL=2, JALR=3.
- Immediates (bit 31 sign-extends):
  - I: code[31:20].
  - S: {code[31:25], code[11:7]}.
  - B: {code[31], code[7], code[30:25], code[11:8], 0}.
  - U: {code[31:12], 12'b0}.
  - J: {code[31], code[19:12], code[20], code[30:21], 0}.
  - R-type and unknown opcodes: imm=0.
- OP (0110011):
  - A=RS1, B=RS2, wb=1.
  - ALU from funct3; funct7[5] selects SUB for ADD and SRA for SRL.
- OP-IMM (0010011):
  - I-imm, A=RS1, B=IMM, wb=1.
  - ALU from funct3. No SUB; funct7[5] selects SRAI for funct3=101.
- LOAD (0000011): ADD, A=RS1, B=IMM, I-imm, wb=1.
- STORE (0100011): ADD, A=RS1, B=IMM, S-imm, wb=0.
- BRANCH (1100011):
  - B-imm, A=RS1, B=RS2, pc=BRANCH, wb=0.
  - ALU by funct3: BEQ→SEQ, BNE→SNE, BLT→SLT, BGE→SGE, BLTU→SLTU, BGEU→SGEU. The branch is taken when ALU result bit 0 is 1.
  - Undefined funct3 (010, 011): ALU=SEQ.
- LUI (0110111): ADD, A=ZERO, B=IMM, U-imm, wb=1.
- AUIPC (0010111): ADD, A=PC, B=IMM, U-imm, wb=1.
- JAL (1101111): ADD, A=PC, B=FOUR, J-imm, pc=JAL, wb=1. Target is pc+imm, computed externally.
- JALR (1100111): ADD, A=PC, B=FOUR, I-imm, pc=JALR, wb=1.
- Any other opcode, including all-zero: NOP. ALU=ADD, selects 0, imm=0, wb=0, pc=PLUS4.
- rd=x0 forces wb_reg=0.
- Reset asserted mid-stream clears outputs immediately. The first instruction after release appears one edge later.

Optional Feature:
- Macro: ILLEGAL_INSN_EN.
- When defined: add output `illegal` (1 bit, registered, reset 0). It is 1 for:
  - unknown opcode;
  - code[1:0]≠11;
  - undefined BRANCH funct3;
  - OP funct7 not 0000000 or 0100000;
  - illegal shift funct7.
- Decoded controls are unchanged; NOP behaviour still applies.
- When undefined: no port, no logic.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode constants;
  - ALU_OP_WIDTH and ALU_* codes;
  - SEL_SRC_A_WIDTH/SRC_A_*, SEL_SRC_B_WIDTH/SRC_B_*, SEL_PC_WIDTH/PC_*.
- Sub-module imm_gen (combinational): code → 32-bit immediate by opcode format.

Test Plan:
- I-type, code=0xF0F08113 → rs1=1, rd=2, imm=0xFFFFFF0F, alu=ADD, A=RS1, B=IMM, pc=PLUS4, wb=1.
- S-type, code=0xFE110023 → rs1=2, rs2=1, rd=0, imm=0xFFFFFFE0, alu=ADD, B=IMM, wb=0.
- B-type BEQ, code=0x222085E3 → rs1=1, rs2=2, imm=0x00000A2A, alu=SEQ, A=RS1, B=RS2, pc=BRANCH, wb=0.
- LUI, code=0xF0F0F0B7 → rd=1, imm=0xF0F0F000, A=ZERO, B=IMM, wb=1.
- JAL, code=0x801000EF → rd=1, imm=0xFFF00800, A=PC, B=FOUR, pc=JAL, wb=1.
- Reset and NOP:
  - Assert rst_n=0 mid-stream → all outputs 0 without waiting for a clock.
  - code=0 after release → NOP outputs (wb=0, imm=0).
